// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial add/subtract sequencer for an external 1-bit full adder cell.
// The block loads two WIDTH-bit operands on an accepted start. It then presents
// one bit pair plus the stored carry per clock, LSB first, on fa_a/fa_b/fa_cin.
// Each cycle it captures fa_s/fa_cout from the cell, and it assembles the
// result, the final carry and the two's-complement overflow.
//
// Subtraction is a + ~b + 1. The operand B is inverted at load time, and the
// carry register is seeded with 1.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      operation request, sampled only while idle
//   sub        in   1      0: a+b, 1: a-b (sampled with start)
//   op_a       in   WIDTH  operand A (sampled with start)
//   op_b       in   WIDTH  operand B (sampled with start)
//   fa_a       out  1      to full adder a input
//   fa_b       out  1      to full adder b input
//   fa_cin     out  1      to full adder carry-in
//   fa_s       in   1      from full adder sum
//   fa_cout    in   1      from full adder carry-out
//   busy       out  1      high while an operation is running or completing
//   done       out  1      one-cycle pulse, result fields valid
//   result     out  WIDTH  sum/difference, held until the next accepted start
//   carry_out  out  1      final carry (subtract: 1 = no borrow)
//   overflow   out  1      two's-complement overflow
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_out_r;
    logic             overflow_r;
    logic             busy_r;
    logic             done_r;

    // Next-state and datapath control decode
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_BIT) begin
                    last_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and the status flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Operand shifters, carry, bit counter and result assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (load_s) begin
            a_r     <= op_a;
            b_r     <= sub ? ~op_b : op_b;
            carry_r <= sub;
            cnt_r   <= '0;
        end else if (step_s) begin
            // Sum bits arrive LSB first and are shifted in from the top.
            result_r <= {fa_s, result_r[WIDTH-1:1]};
            carry_r  <= fa_cout;
            a_r      <= {1'b0, a_r[WIDTH-1:1]};
            b_r      <= {1'b0, b_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CW'(1);
            if (last_s) begin
                // At the MSB, the carry in and the carry out disagree exactly on signed overflow.
                overflow_r  <= carry_r ^ fa_cout;
                carry_out_r <= fa_cout;
            end else begin
                overflow_r  <= overflow_r;
                carry_out_r <= carry_out_r;
            end
        end else begin
            a_r         <= a_r;
            b_r         <= b_r;
            carry_r     <= carry_r;
            cnt_r       <= cnt_r;
            result_r    <= result_r;
            carry_out_r <= carry_out_r;
            overflow_r  <= overflow_r;
        end
    end

    // Full adder drive: live bit pair and carry only while running, quiet otherwise
    always_comb begin
        if (state_r == ST_RUN) begin
            fa_a   = a_r[0];
            fa_b   = b_r[0];
            fa_cin = carry_r;
        end else begin
            fa_a   = 1'b0;
            fa_b   = 1'b0;
            fa_cin = 1'b0;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Bench for serial_add_ctrl with WIDTH=8. The fa_* ports loop through a
// behavioural full adder. Expected results come from plain integer arithmetic
// (unsigned sum/difference, signed range test).
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_s      (fa_s),
        .fa_cout   (fa_cout),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Behavioural full adder cell
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned arithmetic for result/carry, signed range for overflow
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [7:0] er, output logic ec, output logic eo);
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        r  = s ? (sa - sb) : (sa + sb);
        eo = (r > 127) || (r < -128);
        er = 8'(s ? (ua - ub) : (ua + ub));
        ec = s ? (ua >= ub) : ((ua + ub) > 255);
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
        logic [7:0] er;
        logic       ec;
        logic       eo;
        int         n;
        bit         seen;
        model(a, b, s, er, ec, eo);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; sub = s;
        @(posedge clk); #1;
        start = 1'b0;
        op_a  = 8'($urandom);
        op_b  = 8'($urandom);
        sub   = 1'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_fa0"}, {29'd0, fa_a, fa_b, fa_cin}, {29'd0, a[0], b[0] ^ s, s});
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
        end
        check({tag, "_lat"}, 32'(n), 32'd8);
        check({tag, "_res"}, 32'(result), 32'(er));
        check({tag, "_cy"}, 32'(carry_out), 32'(ec));
        check({tag, "_ov"}, 32'(overflow), 32'(eo));
        @(posedge clk); #1;
        check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        logic [7:0] er;
        logic       ec;
        logic       eo;
        int         ndone;
        int         d1;
        int         d2;
        logic [7:0] cap;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = 8'd0; op_b = 8'd0;
        #23;
        check("rst_outs", {25'd0, busy, done, carry_out, overflow, fa_a, fa_b, fa_cin}, 32'd0);
        check("rst_res", 32'(result), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed corner cases
        do_op(8'h35, 8'h4A, 1'b0, "add_35_4a");
        do_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        do_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
        do_op(8'h10, 8'h20, 1'b1, "sub_10_20");
        do_op(8'h80, 8'h01, 1'b1, "sub_80_01");
        do_op(8'h00, 8'h00, 1'b1, "sub_00_00");
        do_op(8'hFF, 8'hFF, 1'b0, "add_ff_ff");

        // Start re-pulsed during RUN and during DONE: ignored
        model(8'h12, 8'h34, 1'b0, er, ec, eo);
        @(negedge clk);
        start = 1'b1; op_a = 8'h12; op_b = 8'h34; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        cap = 8'h00;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                cap = result;
            end
            if (i == 3 || i == 8) begin
                start = 1'b1; op_a = 8'hAA; op_b = 8'h55; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("repulse_ndone", 32'(ndone), 32'd1);
        check("repulse_res", 32'(cap), 32'(er));
        check("repulse_idle", 32'(busy), 32'd0);

        // Start held high across two operations
        @(negedge clk);
        start = 1'b1; op_a = 8'h01; op_b = 8'h02; sub = 1'b0;
        @(posedge clk); #1;
        op_a = 8'h03; op_b = 8'h04;
        d1 = -1;
        for (int i = 0; i < 20 && d1 < 0; i++) begin
            @(posedge clk); #1;
            if (done) d1 = cyc;
        end
        check("held_res1", 32'(result), 32'h03);
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        check("held_busy2", 32'(busy), 32'd1);
        d2 = -1;
        for (int i = 0; i < 20 && d2 < 0; i++) begin
            @(posedge clk); #1;
            if (done) d2 = cyc;
        end
        check("held_res2", 32'(result), 32'h07);
        check("held_gap", 32'(d2 - d1), 32'd10);
        @(posedge clk); #1;
        check("held_stop", 32'(busy), 32'd0);

        // Asynchronous reset after four bits of a running operation
        @(negedge clk);
        start = 1'b1; op_a = 8'h5A; op_b = 8'h3C; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outs", {25'd0, busy, done, carry_out, overflow, fa_a, fa_b, fa_cin}, 32'd0);
        check("arst_res", 32'(result), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("arst_quiet", 32'(ndone), 32'd0);
        do_op(8'h22, 8'h11, 1'b0, "post_rst");

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 24; k++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
